// File: rtl/bus_xfer_pkg.sv
// Shared types and helpers for the bus transfer mux.
// No logic of its own; pure types, constants and combinational helper functions.
// Backpressure: not applicable.
// Contents: state enum, owner index type, master count, default burst limit,
//           grant popcount and grant-to-index encoder.
package bus_xfer_pkg;

  localparam int NUM_M         = 4;
  localparam int MAX_BEATS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_RELEASE = 2'd3
  } xfer_state_e;

  typedef logic [1:0] owner_t;

  // Number of asserted grants, used to tell one-hot from collision.
  function automatic logic [2:0] gnt_count(input logic [NUM_M-1:0] g);
    return 3'(g[0]) + 3'(g[1]) + 3'(g[2]) + 3'(g[3]);
  endfunction

  // Index of the asserted grant; only meaningful when exactly one is set.
  function automatic owner_t gnt_index(input logic [NUM_M-1:0] g);
    owner_t idx;
    idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (g[i]) idx = owner_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_out_stage.sv
// One-deep registered valid/data/last slice feeding the shared slave port.
// Latency: one cycle from load to s_valid_o.
// Backpressure: holds contents while s_valid_o & !s_ready_i; caller loads only when free.
// Ports: clk/rst_n; ld_i with ld_data_i/ld_last_i load a beat; s_ready_i drains it;
//        s_valid_o/s_data_o/s_last_o are the registered slave outputs.
module bus_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  input  logic              s_ready_i,
  output logic              s_valid_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      data_q  <= ld_data_i;
      last_q  <= ld_last_i;
    end else if (s_ready_i) begin
      // Drain: drop valid and last so an empty register never shows a stale last.
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign s_valid_o = valid_q;
  assign s_data_o  = data_q;
  assign s_last_o  = last_q;

endmodule

// File: rtl/bus_xfer_mux.sv
// Latches the granted master as bus owner and forwards its burst to one slave port.
// Latency: grant->ready 1 cycle, master beat->slave 1 cycle; 1 beat/cycle when s_ready high.
// Backpressure: owner ready = !s_valid | s_ready in XFER, else 0; s_* hold while stalled.
// Ports: clk, rst_n; gnt0..3 from the arbiter; mN_valid/data/last/ready per master;
//        s_valid/data/last/ready to the slave; busy, doneN completion pulses, err pulse.
module bus_xfer_mux
  import bus_xfer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt0,
  input  logic              gnt1,
  input  logic              gnt2,
  input  logic              gnt3,
  input  logic              m0_valid,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_last,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_last,
  output logic              m1_ready,
  input  logic              m2_valid,
  input  logic [DATA_W-1:0] m2_data,
  input  logic              m2_last,
  output logic              m2_ready,
  input  logic              m3_valid,
  input  logic [DATA_W-1:0] m3_data,
  input  logic              m3_last,
  output logic              m3_ready,
  output logic              s_valid,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  input  logic              s_ready,
  output logic              busy,
  output logic              done0,
  output logic              done1,
  output logic              done2,
  output logic              done3,
  output logic              err
);

  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic [NUM_M-1:0]  gnt;
  logic [NUM_M-1:0]  m_valid;
  logic [NUM_M-1:0]  m_last;
  logic [NUM_M-1:0]  m_ready;
  logic [DATA_W-1:0] m_data [NUM_M];

  assign gnt     = {gnt3, gnt2, gnt1, gnt0};
  assign m_valid = {m3_valid, m2_valid, m1_valid, m0_valid};
  assign m_last  = {m3_last, m2_last, m1_last, m0_last};
  assign m_data[0] = m0_data;
  assign m_data[1] = m1_data;
  assign m_data[2] = m2_data;
  assign m_data[3] = m3_data;

  xfer_state_e       state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [NUM_M-1:0]  done_q, done_d;
  logic              err_q, err_d;

  logic              own_gnt;
  logic              own_ready;
  logic              accept;
  logic              at_max;
  logic              beat_last;

  assign own_gnt   = gnt[owner_q];
  // Gating with the owner's grant means no beat is taken in the cycle the grant drops.
  assign own_ready = (state_q == ST_XFER) && own_gnt && (!s_valid || s_ready);
  assign accept    = own_ready && m_valid[owner_q];
  assign at_max    = (cnt_q == CW'(MAX_BEATS - 1));
  assign beat_last = m_last[owner_q] || at_max;

  always_comb begin
    m_ready = '0;
    m_ready[owner_q] = own_ready;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (gnt_count(gnt) == 3'd1) begin
          owner_d = gnt_index(gnt);
          cnt_d   = '0;
          state_d = ST_XFER;
        end else if (gnt_count(gnt) > 3'd1) begin
          err_d = 1'b1;
        end
      end
      ST_XFER: begin
        if (!own_gnt) begin
          // Abort: a non-last beat may still sit in the output register.
          err_d = 1'b1;
          if (!s_valid || s_ready) begin
            state_d = ST_IDLE;
          end else begin
            abort_d = 1'b1;
            state_d = ST_FLUSH;
          end
        end else if (accept) begin
          if (!at_max) cnt_d = cnt_q + 1'b1;
          if (beat_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (abort_q) begin
          if (!s_valid || s_ready) begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (s_valid && s_ready && s_last) begin
          done_d[owner_q] = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!own_gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  bus_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_i      (accept),
    .ld_data_i (m_data[owner_q]),
    .ld_last_i (beat_last),
    .s_ready_i (s_ready),
    .s_valid_o (s_valid),
    .s_data_o  (s_data),
    .s_last_o  (s_last)
  );

  assign m0_ready = m_ready[0];
  assign m1_ready = m_ready[1];
  assign m2_ready = m_ready[2];
  assign m3_ready = m_ready[3];
  assign busy     = (state_q != ST_IDLE);
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign done2    = done_q[2];
  assign done3    = done_q[3];
  assign err      = err_q;

endmodule

// File: tb/tb_bus_xfer_mux.sv
// Directed self-checking bench for bus_xfer_mux.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// Each scenario task carries its own hand-computed expectations.
module tb_bus_xfer_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] gnt = '0;
  logic [3:0] mv = '0;
  logic [3:0] ml = '0;
  logic [7:0] md [4];
  logic       s_ready = 1'b0;
  logic [3:0] mr;
  logic [3:0] done;
  logic       s_valid, s_last, busy, err;
  logic [7:0] s_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_xfer_mux #(.DATA_W(8), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
    .m0_valid(mv[0]), .m0_data(md[0]), .m0_last(ml[0]), .m0_ready(mr[0]),
    .m1_valid(mv[1]), .m1_data(md[1]), .m1_last(ml[1]), .m1_ready(mr[1]),
    .m2_valid(mv[2]), .m2_data(md[2]), .m2_last(ml[2]), .m2_ready(mr[2]),
    .m3_valid(mv[3]), .m3_data(md[3]), .m3_last(ml[3]), .m3_ready(mr[3]),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .busy(busy),
    .done0(done[0]), .done1(done[1]), .done2(done[2]), .done3(done[3]),
    .err(err)
  );

  task automatic quiet();
    gnt = '0; mv = '0; ml = '0; s_ready = 1'b1;
    for (int i = 0; i < 4; i++) md[i] = '0;
  endtask

  task automatic test_reset();
    quiet();
    #1;
    n_checks++;
    if ({s_valid, s_last, busy, err, done, mr} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {s_valid, s_last, busy, err, done, mr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b s_valid=%b expected 0 0", busy, s_valid);
    end
  endtask

  task automatic test_basic_burst();
    logic [7:0] d [3];
    d = '{8'h11, 8'h22, 8'h33};
    gnt = 4'b0001; mv[0] = 1'b1; md[0] = d[0]; ml[0] = 1'b0; s_ready = 1'b1;
    #1;
    n_checks++;
    if (mr !== 4'b0000) begin
      n_fail++; $display("FAIL basic_ready_before_latch: got %b expected 0000", mr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (mr !== 4'b0001 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_after_latch: mr=%b s_valid=%b expected 0001 0", mr, s_valid);
    end
    for (int i = 0; i < 3; i++) begin
      md[0] = d[i]; ml[0] = (i == 2);
      @(negedge clk); #1;
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== d[i] || s_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: v=%b data=%h last=%b expected 1 %h %b", i, s_valid, s_data, s_last, d[i], (i == 2));
      end
    end
    mv[0] = 1'b0; ml[0] = 1'b0;
    #1;
    n_checks++;
    if (mr !== 4'b0000 || done !== 4'b0000) begin
      n_fail++; $display("FAIL basic_flush: mr=%b done=%b expected 0000 0000", mr, done);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 4'b0001 || s_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: done=%b s_valid=%b busy=%b expected 0001 0 1", done, s_valid, busy);
    end
    gnt = 4'b0000;
    @(negedge clk); #1;
    n_checks++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: done=%b busy=%b expected 0000 0", done, busy);
    end
  endtask

  task automatic test_max_beats();
    gnt = 4'b1000; mv[3] = 1'b1; ml[3] = 1'b0; md[3] = 8'hA0; s_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      md[3] = 8'(8'hA0 + i);
      #1;
      n_checks++;
      if (mr !== 4'b1000) begin
        n_fail++; $display("FAIL max_ready%0d: got %b expected 1000", i, mr);
      end
      @(negedge clk); #1;
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== 8'(8'hA0 + i) || s_last !== (i == 7)) begin
        n_fail++;
        $display("FAIL max_beat%0d: v=%b data=%h last=%b expected 1 %h %b", i, s_valid, s_data, s_last, 8'(8'hA0 + i), (i == 7));
      end
    end
    n_checks++;
    if (mr !== 4'b0000) begin
      n_fail++; $display("FAIL max_ready_drop: got %b expected 0000", mr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 4'b1000 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL max_done: done=%b s_valid=%b expected 1000 0", done, s_valid);
    end
    quiet();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    int          sent;
    int          rcv;
    logic        held;
    logic [7:0]  held_data;
    logic        done_seen;
    pat = 16'b1011_0010_0110_1001;
    sent = 0; rcv = 0; held = 1'b0; held_data = '0; done_seen = 1'b0;
    gnt = 4'b0100; s_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 40 && !done_seen; c++) begin
      s_ready = pat[c % 16];
      mv[2] = (sent < 4); md[2] = 8'(8'h40 + sent); ml[2] = (sent == 3);
      #1;
      if (held) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== held_data) begin
          n_fail++; $display("FAIL bp_hold: v=%b data=%h expected 1 %h", s_valid, s_data, held_data);
        end
      end
      if (s_valid && !s_ready) begin
        n_checks++;
        if (mr !== 4'b0000) begin
          n_fail++; $display("FAIL bp_ready_stalled: got %b expected 0000", mr);
        end
      end
      if (s_valid && s_ready) begin
        n_checks++;
        if (s_data !== 8'(8'h40 + rcv) || s_last !== (rcv == 3)) begin
          n_fail++; $display("FAIL bp_beat%0d: data=%h last=%b expected %h %b", rcv, s_data, s_last, 8'(8'h40 + rcv), (rcv == 3));
        end
        rcv++;
      end
      if (mr[2] && mv[2]) sent++;
      held = s_valid && !s_ready;
      held_data = s_data;
      @(negedge clk); #1;
      if (done[2]) done_seen = 1'b1;
    end
    n_checks++;
    if (rcv !== 4 || done_seen !== 1'b1) begin
      n_fail++; $display("FAIL bp_complete: beats=%0d done_seen=%b expected 4 1", rcv, done_seen);
    end
    quiet();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort();
    gnt = 4'b0010; mv[1] = 1'b1; md[1] = 8'h51; ml[1] = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    md[1] = 8'h52;
    @(negedge clk);
    gnt = 4'b0000; s_ready = 1'b0; md[1] = 8'h53;
    #1;
    n_checks++;
    if (mr !== 4'b0000) begin
      n_fail++; $display("FAIL abort_ready: got %b expected 0000", mr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || s_valid !== 1'b1 || s_data !== 8'h52 || s_last !== 1'b0 || busy !== 1'b1 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_err: err=%b v=%b data=%h last=%b busy=%b done=%b expected 1 1 52 0 1 0000", err, s_valid, s_data, s_last, busy, done);
    end
    s_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0 || s_valid !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin
      n_fail++; $display("FAIL abort_drain: err=%b v=%b busy=%b done=%b expected 0 0 0 0000", err, s_valid, busy, done);
    end
    quiet();
    @(negedge clk);
  endtask

  task automatic test_multi_grant();
    gnt = 4'b0110;
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || mr !== 4'b0) begin
      n_fail++; $display("FAIL multi_err: err=%b busy=%b mr=%b expected 1 0 0000", err, busy, mr);
    end
    gnt = 4'b0000;
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL multi_clear: err=%b busy=%b expected 0 0", err, busy);
    end
  endtask

  task automatic test_nonowner_grant();
    gnt = 4'b1000; mv[3] = 1'b1; md[3] = 8'h77; ml[3] = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    gnt = 4'b1001; mv[0] = 1'b1; md[0] = 8'hEE;
    #1;
    n_checks++;
    if (mr !== 4'b1000) begin
      n_fail++; $display("FAIL nonowner_ready: got %b expected 1000", mr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0 || s_data !== 8'h77 || mr !== 4'b1000) begin
      n_fail++; $display("FAIL nonowner_beat: err=%b data=%h mr=%b expected 0 77 1000", err, s_data, mr);
    end
    md[3] = 8'h78; ml[3] = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0 || s_data !== 8'h78 || s_last !== 1'b1) begin
      n_fail++; $display("FAIL nonowner_last: err=%b data=%h last=%b expected 0 78 1", err, s_data, s_last);
    end
    mv = '0;
    @(negedge clk); #1;
    n_checks++;
    if (done !== 4'b1000 || err !== 1'b0) begin
      n_fail++; $display("FAIL nonowner_done: done=%b err=%b expected 1000 0", done, err);
    end
    quiet();
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL nonowner_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    gnt = 4'b0001; mv[0] = 1'b1; md[0] = 8'h99; ml[0] = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (s_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_active: v=%b busy=%b expected 1 1", s_valid, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_valid, s_last, busy, err, done, mr} !== 11'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b expected 0", {s_valid, s_last, busy, err, done, mr});
    end
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || s_valid !== 1'b0 || mr !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_idle: busy=%b v=%b mr=%b expected 0 0 0000", busy, s_valid, mr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_max_beats();
    test_backpressure();
    test_abort();
    test_multi_grant();
    test_nonowner_grant();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_xfer_mux.md
# bus_xfer_mux

Downstream stage of the 4-requester round-robin arbiter. Consumes the arbiter's one-hot grants `gnt3..gnt0`, latches the granted master as bus owner and forwards that master's burst onto a single shared slave port through a one-deep registered output stage. Counts beats and enforces a maximum burst length. Reports completion per master so the master can drop its request and let the arbiter re-arbitrate.

## Interface
- `DATA_W`, default 8: data width of every master and slave data port.
- `MAX_BEATS`, default 8: maximum beats per burst, range 2..256. The beat that reaches this count is forced to be last.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `gnt3..gnt0`, in, 1 each: grants from the arbiter. Expected one-hot or zero.
- `mN_valid`, in, 1 (N=0..3): master N beat valid.
- `mN_data`, in, `DATA_W`: master N beat data.
- `mN_last`, in, 1: master N final beat of the burst.
- `mN_ready`, out, 1: master N beat accepted when `mN_valid & mN_ready`.
- `s_valid`, out, 1: slave beat valid, registered.
- `s_data`, out, `DATA_W`: slave data, registered.
- `s_last`, out, 1: slave final beat, registered.
- `s_ready`, in, 1: slave accepts.
- `busy`, out, 1: high in every state except IDLE.
- `done3..done0`, out, 1 each: one-cycle completion pulse to the owner.
- `err`, out, 1: one-cycle protocol-error pulse.

## Operation
The block is a four-state FSM: IDLE, XFER, FLUSH, RELEASE.

- **Reset values.** All outputs are 0. State is IDLE, owner is 0, beat count is 0, and the output register is empty.
- **IDLE**
  - Exactly one `gnt` high: latch the owner index, clear the beat count, go to XFER.
  - More than one `gnt` high: pulse `err` and stay in IDLE.
  - No `gnt`: stay in IDLE.
- **XFER**
  - Ready rule: `m<owner>_ready = !s_valid | s_ready`. All other `mN_ready` are 0.
  - Accepted beat: load the output register. `s_last = mN_last | (count == MAX_BEATS-1)`, then increment the count.
  - If the accepted beat is last, per the rule above, go to FLUSH.
- **FLUSH**
  - `mN_ready` is 0 for every master.
  - When the slave accepts a beat with `s_last`, pulse `done<owner>` and go to RELEASE.
- **RELEASE**
  - Wait until `gnt<owner>` is 0, then go to IDLE.
  - New grants are ignored until the block is back in IDLE.
- **Owner grant drops during XFER (abort).**
  - Pulse `err` and stop accepting beats.
  - Any beat already in the output register still drains. It keeps its stored `s_last` and no `s_last` is forced.
  - Go to IDLE once the register is empty. No `done` is pulsed.
- **Grant on a non-owner master while busy.** Ignored; no error.
- **Beat counter.** Width `$clog2(MAX_BEATS)`. It never wraps, because the forced-last rule ends the burst first.
- **Asynchronous reset at any point.** Returns immediately to the reset values. Any in-flight beat is discarded.

## Timing
- **Grant to ready.** If the grant is seen in cycle T, `mN_ready` can first be high in cycle T+1, because the owner is registered.
- **Master to slave.** A beat accepted from the master at edge E appears on `s_*` after E, i.e. one cycle of latency.
- **Throughput.** With `s_ready` held high, one beat per cycle.
- **Back-pressure.** When `s_ready` is low with `s_valid` high, `s_*` holds stable and `mN_ready` is 0.
- **Done pulse.** `done` is high for exactly the one cycle following the slave's acceptance of the last beat.
- **Burst turnaround.** Minimum from the last slave acceptance to the next owner latch is 2 cycles (RELEASE, then IDLE), plus the time the master takes to drop its request.

## Structure
- **Package `bus_xfer_pkg`** holds:
  - the state enum `xfer_state_e` (IDLE, XFER, FLUSH, RELEASE);
  - the owner index type (2 bits);
  - the number of masters, `NUM_M = 4`;
  - the `MAX_BEATS` default.
- **Sub-module `bus_out_stage`:** the one-deep registered valid/data/last slice with the load/hold/drain rule. The FSM, owner mux and counter stay in the top module.

## Test plan
1. Reset with `rst_n = 0` during active traffic → all outputs 0 the cycle reset asserts. Release → IDLE with `busy = 0`.
2. `gnt0` high; m0 sends 3 beats 0x11, 0x22, 0x33 (`last` on 0x33); `s_ready = 1` → `s_data` shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance. `s_last` only on 0x33. `done0` pulses once.
3. `gnt3` high; m3 streams with no `last`; `MAX_BEATS = 8` → beat 8 carries `s_last = 1`, `m3_ready` drops after beat 8, `done3` pulses.
4. `s_ready` toggles 0/1 during an m2 burst → `s_data` stable while stalled, no beat lost or duplicated.
5. `gnt1` drops after 2 of 5 m1 beats → `err` pulses, the registered beat drains, `done1` stays 0, block returns to IDLE.
6. `gnt2` and `gnt1` both high in IDLE → `err` pulse, `busy = 0`. Owner m3 busy while `gnt0` rises → ignored, no `err`.
